// File: rtl/ifetch_byte_assembler.sv
// Instruction-fetch front end: reads a byte-wide instruction memory one byte
// per cycle, assembles big-endian 32-bit words (byte 0 = MSB), buffers up to
// two words with their PCs and presents them on a valid/ready interface.
// Branch/jump redirects flush everything buffered or in flight.
//
// Handshake (inst_*): a word transfers on every rising edge where
// inst_valid & inst_ready are both 1. While inst_valid=1 and inst_ready=0,
// inst_word and inst_pc hold steady. inst_valid never depends on inst_ready.
module ifetch_byte_assembler #(
   parameter int          IMEM_AW  = 5,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_rd,
   output logic [IMEM_AW-1:0] mem_addr,
   input  logic [7:0]         mem_data,
   input  logic               redir_valid,
   input  logic [31:0]        redir_pc,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [31:0]        inst_word,
   output logic [31:0]        inst_pc,
   output logic               align_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BYTE  = 2'd1,
      S_STALL = 2'd2
   } state_t;

   state_t      state, state_d;
   logic [1:0]  cnt, cnt_d;
   logic [31:0] fetch_pc, fetch_pc_d;

   // Read pipeline: a byte requested this cycle comes back next cycle.
   logic        inflight_q;
   logic        last_q;
   logic [31:0] asm_word;
   logic [31:0] asm_pc;
   logic [1:0]  asm_words;

   // Two-entry instruction FIFO.
   logic [31:0] fifo_word [2];
   logic [31:0] fifo_pc   [2];
   logic        wr_ptr, rd_ptr;
   logic [1:0]  fifo_cnt;

   logic        push, pop, issue_first;
   logic [31:0] push_word;
   logic [2:0]  occupancy;
   logic        slot_free;
   logic        align_q;

   assign pop         = inst_valid & inst_ready;
   assign push        = inflight_q & last_q & ~redir_valid;
   assign push_word   = {asm_word[23:0], mem_data};
   assign issue_first = mem_rd & (cnt == 2'd0);

   // Words buffered plus words being assembled; a pop this cycle frees a slot.
   assign occupancy = {1'b0, fifo_cnt} + {1'b0, asm_words} - {2'b00, pop};
   assign slot_free = occupancy < 3'd2;

   assign mem_rd   = (state == S_BYTE);
   assign mem_addr = mem_rd ? (fetch_pc[IMEM_AW-1:0] + IMEM_AW'(cnt)) : '0;

   assign inst_valid = (fifo_cnt != 2'd0);
   assign inst_word  = fifo_word[rd_ptr];
   assign inst_pc    = fifo_pc[rd_ptr];
   assign align_err  = align_q;

   // Fetch FSM state, byte counter and fetch PC registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 2'd0;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         fetch_pc <= fetch_pc_d;
      end
   end

   // Next-state logic; a redirect overrides every state.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      fetch_pc_d = fetch_pc;
      case (state)
         S_IDLE: begin
            cnt_d   = 2'd0;
            state_d = slot_free ? S_BYTE : S_STALL;
         end
         S_BYTE: begin
            cnt_d = cnt + 2'd1;
            if (cnt == 2'd3) begin
               fetch_pc_d = fetch_pc + 32'd4;
               state_d    = slot_free ? S_BYTE : S_STALL;
            end
         end
         S_STALL: begin
            if (slot_free) begin
               cnt_d   = 2'd0;
               state_d = S_BYTE;
            end
         end
         default: begin
            cnt_d   = 2'd0;
            state_d = S_IDLE;
         end
      endcase
      if (redir_valid) begin
         cnt_d      = 2'd0;
         fetch_pc_d = {redir_pc[31:2], 2'b00};
         state_d    = S_BYTE;
      end
   end

   // Byte return tracking and word assembly; redirect squashes in-flight data.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         last_q     <= 1'b0;
         asm_word   <= 32'd0;
         asm_pc     <= RESET_PC;
         asm_words  <= 2'd0;
      end else if (redir_valid) begin
         inflight_q <= 1'b0;
         last_q     <= 1'b0;
         asm_word   <= 32'd0;
         asm_words  <= 2'd0;
      end else begin
         inflight_q <= mem_rd;
         last_q     <= mem_rd & (cnt == 2'd3);
         if (inflight_q) begin
            asm_word <= push_word;
         end
         if (issue_first) begin
            asm_pc <= fetch_pc;
         end
         asm_words <= asm_words + {1'b0, issue_first} - {1'b0, push};
      end
   end

   // Instruction FIFO: push on the fourth returned byte, pop on handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_cnt     <= 2'd0;
         fifo_word[0] <= 32'd0;
         fifo_word[1] <= 32'd0;
         fifo_pc[0]   <= RESET_PC;
         fifo_pc[1]   <= RESET_PC;
      end else if (redir_valid) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push) begin
            fifo_word[wr_ptr] <= push_word;
            fifo_pc[wr_ptr]   <= asm_pc;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   // One-cycle misaligned-redirect flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         align_q <= 1'b0;
      end else begin
         align_q <= redir_valid & (redir_pc[1:0] != 2'b00);
      end
   end

endmodule

// File: tb/tb_ifetch_byte_assembler.sv
// Directed bench for ifetch_byte_assembler: a byte memory model, a table of
// redirect vectors and hand-written multi-cycle sequences.
module tb_ifetch_byte_assembler;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rd;
   logic [4:0]  mem_addr;
   logic [7:0]  mem_data;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_word;
   logic [31:0] inst_pc;
   logic        align_err;

   int n_vec  = 0;
   int n_fail = 0;

   logic [7:0] mem [32];

   typedef struct {
      logic [31:0] redir_pc;
      logic        align;
      logic [4:0]  addr0;
      logic [31:0] pc1;
      logic [31:0] word1;
      logic [31:0] pc2;
      logic [31:0] word2;
   } vec_t;

   vec_t vecs [6];

   ifetch_byte_assembler #(.IMEM_AW(5), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_word   (inst_word),
      .inst_pc     (inst_pc),
      .align_err   (align_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   // byte memory: data valid the cycle after the read strobe
   always @(posedge clk) begin
      mem_data <= mem_rd ? mem[mem_addr] : 8'hEE;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      redir_valid = 1'b0;
      redir_pc    = 32'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
      check({tag, "_word"},  inst_word, 32'd0);
      check({tag, "_pc"},    inst_pc, 32'd0);
      check({tag, "_rd"},    {31'd0, mem_rd}, 32'd0);
      check({tag, "_addr"},  {27'd0, mem_addr}, 32'd0);
      check({tag, "_align"}, {31'd0, align_err}, 32'd0);
   endtask

   // waits (bounded) until inst_valid; n = ticks spent
   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (!inst_valid && n < max) begin
         tick();
         n++;
      end
      check("valid_timeout", {31'd0, inst_valid}, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] pc);
      redir_valid = 1'b1;
      redir_pc    = pc;
      tick();
      redir_valid = 1'b0;
   endtask

   initial begin
      int n;
      int rd_count;
      int head_bad;

      for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
      mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;

      vecs[0] = '{32'h0000_0013, 1'b1, 5'h10, 32'h0000_0010, 32'h5051_5253, 32'h0000_0014, 32'h5455_5657};
      vecs[1] = '{32'h0000_001C, 1'b0, 5'h1C, 32'h0000_001C, 32'h5C5D_5E5F, 32'h0000_0020, 32'h8C22_0004};
      vecs[2] = '{32'h0000_0004, 1'b0, 5'h04, 32'h0000_0004, 32'h4445_4647, 32'h0000_0008, 32'h4849_4A4B};
      vecs[3] = '{32'h0000_001E, 1'b1, 5'h1C, 32'h0000_001C, 32'h5C5D_5E5F, 32'h0000_0020, 32'h8C22_0004};
      vecs[4] = '{32'h0000_003E, 1'b1, 5'h1C, 32'h0000_003C, 32'h5C5D_5E5F, 32'h0000_0040, 32'h8C22_0004};
      vecs[5] = '{32'hFFFF_FFFD, 1'b1, 5'h1C, 32'hFFFF_FFFC, 32'h5C5D_5E5F, 32'h0000_0000, 32'h8C22_0004};

      // --- reset fetch with ready=1: latency and throughput
      inst_ready = 1'b1;
      do_reset();
      check_reset_values("rst");
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t1_rd", {31'd0, mem_rd}, 32'd1);
         check("t1_addr", {27'd0, mem_addr}, i);
         tick();
      end
      check("t1_valid_early", {31'd0, inst_valid}, 32'd0);
      tick();
      check("t1_valid_5", {31'd0, inst_valid}, 32'd1);
      check("t1_word0", inst_word, 32'h8C22_0004);
      check("t1_pc0", inst_pc, 32'h0);
      tick();
      wait_valid(20, n);
      check("t1_gap", n, 3);
      check("t1_pc1", inst_pc, 32'h4);
      check("t1_word1", inst_word, 32'h4445_4647);

      // --- backpressure: exactly two words, fetch stops, head stable
      inst_ready = 1'b0;
      do_reset();
      rd_count = 0;
      head_bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (mem_rd) rd_count++;
         if (inst_valid && (inst_pc !== 32'h0 || inst_word !== 32'h8C22_0004)) head_bad++;
      end
      check("t2_rd_count", rd_count, 8);
      check("t2_head_stable", head_bad, 0);
      check("t2_valid", {31'd0, inst_valid}, 32'd1);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("t2_valid_after_pop", {31'd0, inst_valid}, 32'd1);
      check("t2_pc_after_pop", inst_pc, 32'h4);
      check("t2_word_after_pop", inst_word, 32'h4445_4647);
      check("t2_restart_rd", {31'd0, mem_rd}, 32'd1);
      check("t2_restart_addr", {27'd0, mem_addr}, 32'h8);

      // --- redirect mid-word (cnt=2 of second word, one word buffered)
      inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 7; i++) tick();
      check("t3_pre_addr", {27'd0, mem_addr}, 32'h6);
      check("t3_pre_valid", {31'd0, inst_valid}, 32'd1);
      redirect(32'h10);
      check("t3_flush", {31'd0, inst_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("t3_rd", {31'd0, mem_rd}, 32'd1);
         check("t3_addr", {27'd0, mem_addr}, 32'h10 + i);
         tick();
      end
      inst_ready = 1'b1;
      wait_valid(20, n);
      check("t3_latency", n, 1);
      check("t3_pc", inst_pc, 32'h10);
      check("t3_word", inst_word, 32'h5051_5253);

      // --- table of redirects: alignment, memory wrap, PC wrap
      for (int v = 0; v < 6; v++) begin
         redirect(vecs[v].redir_pc);
         check($sformatf("v%0d_align", v), {31'd0, align_err}, {31'd0, vecs[v].align});
         check($sformatf("v%0d_flush", v), {31'd0, inst_valid}, 32'd0);
         check($sformatf("v%0d_rd", v), {31'd0, mem_rd}, 32'd1);
         check($sformatf("v%0d_addr0", v), {27'd0, mem_addr}, {27'd0, vecs[v].addr0});
         tick();
         check($sformatf("v%0d_align_pulse", v), {31'd0, align_err}, 32'd0);
         wait_valid(20, n);
         check($sformatf("v%0d_latency", v), n, 4);
         check($sformatf("v%0d_pc1", v), inst_pc, vecs[v].pc1);
         check($sformatf("v%0d_word1", v), inst_word, vecs[v].word1);
         tick();
         wait_valid(20, n);
         check($sformatf("v%0d_gap", v), n, 3);
         check($sformatf("v%0d_pc2", v), inst_pc, vecs[v].pc2);
         check($sformatf("v%0d_word2", v), inst_word, vecs[v].word2);
      end

      // --- redirect in the same cycle as a pop: no replay
      inst_ready = 1'b1;
      do_reset();
      wait_valid(20, n);
      check("t6_pop_pc", inst_pc, 32'h0);
      redirect(32'h8);
      check("t6_flush", {31'd0, inst_valid}, 32'd0);
      wait_valid(20, n);
      check("t6_no_replay_pc", inst_pc, 32'h8);
      check("t6_word", inst_word, 32'h4849_4A4B);

      // --- reset asserted at cnt=3 with a word buffered
      inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) tick();
      check("t7_pre_addr", {27'd0, mem_addr}, 32'h7);
      check("t7_pre_valid", {31'd0, inst_valid}, 32'd1);
      rst = 1'b1;
      tick();
      check_reset_values("t7");
      rst = 1'b0;
      tick();
      check("t7_resume_rd", {31'd0, mem_rd}, 32'd1);
      check("t7_resume_addr", {27'd0, mem_addr}, 32'h0);
      inst_ready = 1'b1;
      wait_valid(20, n);
      check("t7_latency", n, 5);
      check("t7_pc", inst_pc, 32'h0);
      check("t7_word", inst_word, 32'h8C22_0004);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_byte_assembler.md
Name: ifetch_byte_assembler

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle datapath's decode and control.
- Reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit words, byte 0 being the MSB.
- Buffers assembled words with their PCs in a 2-entry FIFO and presents them on a valid/ready interface.
- Accepts branch/jump redirects from the datapath; a redirect flushes everything buffered or in flight.

Parameters:
- IMEM_AW, 5, instruction-memory byte-address width (32 bytes); byte addresses wrap modulo 2^IMEM_AW.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rd  out  1  byte read strobe.
- mem_addr  out  IMEM_AW  byte address for mem_rd.
- mem_data  in  8  read data, valid exactly 1 cycle after mem_rd.
- redir_valid  in  1  redirect request, single-cycle pulse.
- redir_pc  in  32  redirect target.
- inst_valid  out  1  inst_word/inst_pc hold a buffered instruction.
- inst_ready  in  1  consumer accepts the head word this cycle.
- inst_word  out  32  assembled instruction.
- inst_pc  out  32  byte address of inst_word.
- align_err  out  1  1-cycle pulse when a redirect target had redir_pc[1:0] != 0.

Behaviour:
- Reset (rst=1 at a posedge):
  - inst_valid=0, inst_word=0, inst_pc=RESET_PC, mem_rd=0, mem_addr=0, align_err=0.
  - FIFO empty, byte counter=0, in-flight squashed, fetch_pc=RESET_PC, state=S_IDLE.
  - Reset mid-word discards the partial word; mem_data arriving the cycle after reset is ignored.
- FSM states:
  - S_IDLE: one cycle, always goes to S_BYTE, or to S_STALL if no slot is free.
  - S_BYTE: cnt 0..3. Each cycle assert mem_rd with mem_addr=(fetch_pc[IMEM_AW-1:0]+cnt) mod 2^IMEM_AW. At cnt=3, fetch_pc += 4 (32-bit wrap); stay in S_BYTE if a slot is free for the next word, else go to S_STALL.
  - S_STALL: mem_rd=0; go to S_BYTE with cnt=0 once a slot is free.
- Slot accounting:
  - A word is reserved when its cnt=0 read issues.
  - occupancy = FIFO count + words in assembly, and must never exceed 2.
  - A pop in the same cycle frees a slot for that cycle's decision.
- Assembly:
  - A returned byte shifts in as word = {word[23:0], mem_data}.
  - The 4th returned byte pushes {word, pc_of_word} into the FIFO at that posedge; inst_valid is high the next cycle.
  - Latency: first mem_rd occurs the cycle after S_IDLE; the first inst_valid occurs 5 cycles after the first mem_rd.
  - Throughput: 1 word per 4 cycles, with no bubble between words while space exists.
- Handshake:
  - A pop occurs on inst_valid & inst_ready.
  - inst_word and inst_pc are stable while inst_valid=1 and inst_ready=0.
  - Push and pop in the same cycle are both honoured; the FIFO never overflows and never underflows.
- Redirect (priority over everything except rst):
  - Flush the FIFO, squash the returning in-flight byte and the partial word, set cnt=0, fetch_pc={redir_pc[31:2],2'b00}.
  - inst_valid=0 from the next cycle; mem_rd for the new target begins the next cycle.
  - A handshake completing in the same cycle as redir_valid is counted as consumed; nothing is replayed.
  - align_err=1 for the cycle after the redirect if redir_pc[1:0]!=0.
  - A redirect during S_STALL or S_IDLE behaves the same.
- Address wrap: mem_addr wraps at 2^IMEM_AW bytes, including within a word. inst_pc is the full 32-bit fetch_pc and does not wrap with mem_addr.

Test Plan:
1. Reset fetch, ready=1: bytes 0-3 = 8C,22,00,04 -> first mem_rd the cycle after S_IDLE; inst_valid 5 cycles after the first mem_rd with inst_word=8C220004, inst_pc=0; next word inst_pc=4 exactly 4 cycles later.
2. Backpressure: ready=0 -> exactly 2 words buffered, mem_rd stays low afterwards, head word stable. Raise ready for 1 cycle -> pop PC 0, head becomes PC 4, fetch of PC 8 restarts.
3. Redirect mid-word: redir_valid with redir_pc=0x10 at cnt=2 -> inst_valid=0 next cycle, mem_addr sequence 10,11,12,13, next delivered word has inst_pc=0x10 with the correct bytes; no stale byte leaks in.
4. Misaligned redirect: redir_pc=0x13 -> align_err pulses for 1 cycle, fetch starts at 0x10, inst_pc=0x10.
5. Wrap: redir_pc=0x1C, IMEM_AW=5 -> word from 1C..1F with inst_pc=0x1C; next mem_addr=00, and that word's inst_pc=0x20.
6. Corner cases: reset asserted at cnt=3 -> all outputs at reset values next cycle, fetch resumes from RESET_PC. Redirect in the same cycle as a pop -> the popped word is not re-presented.
